// File: rtl/capture_window_buffer.sv
// Pre/post-trigger capture buffer: records ADC samples into a circular RAM and, on a
// trigger edge, streams PRE_SAMPLES of history followed by POST_SAMPLES live samples.
module capture_window_buffer #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int DEPTH             = 512,
    parameter int PRE_SAMPLES       = 64,
    parameter int POST_SAMPLES      = 448
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         axiiv,
    input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
    input  logic                         trigger,
    output logic                         axiov,
    output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
    output logic                         axiol,
    input  logic                         axior,
    output logic                         armed,
    output logic                         busy,
    output logic                         done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int TOTAL = PRE_SAMPLES + POST_SAMPLES;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int HW    = $clog2(PRE_SAMPLES + 1);
    localparam int PW    = $clog2(POST_SAMPLES + 1);

    localparam logic [AW-1:0] PRE_A  = AW'(PRE_SAMPLES);
    localparam logic [HW-1:0] PRE_H  = HW'(PRE_SAMPLES);
    localparam logic [PW-1:0] POST_P = PW'(POST_SAMPLES);
    localparam logic [CW-1:0] PRE_C  = CW'(PRE_SAMPLES);
    localparam logic [CW-1:0] LAST_C = CW'(TOTAL - 1);

    generate
        if (TOTAL > DEPTH) begin : g_window_too_large
            $error("capture_window_buffer: PRE_SAMPLES + POST_SAMPLES exceeds DEPTH");
        end
        if (DEPTH != (1 << AW)) begin : g_depth_not_pow2
            $error("capture_window_buffer: DEPTH must be a power of two");
        end
        if (PRE_SAMPLES < 1 || POST_SAMPLES < 1) begin : g_empty_window
            $error("capture_window_buffer: PRE_SAMPLES and POST_SAMPLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [HW-1:0]                 hist_cnt_q, hist_cnt_d;
    logic [PW-1:0]                 post_cnt_q, post_cnt_d;
    logic [CW-1:0]                 rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]                 out_cnt_q, out_cnt_d;
    logic                          trig_q;
    logic                          done_q, done_d;

    logic                          rd_pend_q, rd_pend_d;
    logic                          rd_last_q, rd_last_d;
    logic                          out_valid_q, out_valid_d;
    logic [SAMPLE_DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                          out_last_q, out_last_d;
    logic                          skid_valid_q, skid_valid_d;
    logic [SAMPLE_DATA_WIDTH-1:0]  skid_data_q, skid_data_d;
    logic                          skid_last_q, skid_last_d;

    logic [SAMPLE_DATA_WIDTH-1:0]  mem [DEPTH];
    logic [SAMPLE_DATA_WIDTH-1:0]  ram_rdata;

    logic                          trig_edge;
    logic                          accept;
    logic                          wr_en;
    logic                          rd_en;
    logic [CW-1:0]                 avail;
    logic [1:0]                    occ;

    assign trig_edge = trigger & ~trig_q;
    assign accept    = out_valid_q & axior;
    assign wr_en     = axiiv & ((state_q != S_CAPTURE) | (post_cnt_q < POST_P));
    assign wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;

    // Availability is tracked by count: when PRE+POST equals DEPTH the pointers
    // coincide while the final sample is still unread.
    assign avail = PRE_C + CW'(post_cnt_q);
    assign occ   = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q);
    assign rd_en = (state_q == S_CAPTURE) && (rd_cnt_q < avail)
                   && ((occ - 2'(accept)) <= 2'd1);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= axiid;
        end
        if (rd_en) begin
            ram_rdata <= mem[rd_ptr_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        hist_cnt_d = hist_cnt_q;
        post_cnt_d = post_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        rd_cnt_d   = rd_cnt_q;
        out_cnt_d  = out_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            S_FILL: begin
                if (wr_en && (hist_cnt_q != PRE_H)) begin
                    hist_cnt_d = hist_cnt_q + HW'(1);
                end
                if (hist_cnt_d == PRE_H) begin
                    state_d = S_ARMED;
                end
            end

            S_ARMED: begin
                if (trig_edge) begin
                    rd_ptr_d   = wr_ptr_q - PRE_A;
                    post_cnt_d = wr_en ? PW'(1) : PW'(0);
                    rd_cnt_d   = '0;
                    out_cnt_d  = '0;
                    state_d    = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                if (wr_en) begin
                    post_cnt_d = post_cnt_q + PW'(1);
                end
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
                if (accept) begin
                    if (out_cnt_q == LAST_C) begin
                        done_d     = 1'b1;
                        out_cnt_d  = '0;
                        hist_cnt_d = '0;
                        state_d    = S_FILL;
                    end else begin
                        out_cnt_d = out_cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d    = S_FILL;
                hist_cnt_d = '0;
            end
        endcase
    end

    // Two-entry output queue (output register plus skid) absorbs the RAM read
    // latency so a stalled consumer never loses an in-flight read.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        rd_pend_d    = rd_en;
        rd_last_d    = (rd_cnt_q == LAST_C);

        if (accept) begin
            out_valid_d  = skid_valid_q;
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            skid_valid_d = 1'b0;
        end

        if (rd_pend_q) begin
            if (!out_valid_d) begin
                out_valid_d = 1'b1;
                out_data_d  = ram_rdata;
                out_last_d  = rd_last_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = ram_rdata;
                skid_last_d  = rd_last_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hist_cnt_q   <= '0;
            post_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            out_cnt_q    <= '0;
            trig_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            hist_cnt_q   <= hist_cnt_d;
            post_cnt_q   <= post_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            out_cnt_q    <= out_cnt_d;
            trig_q       <= trigger;
            done_q       <= done_d;
            rd_pend_q    <= rd_pend_d;
            rd_last_q    <= rd_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
        end
    end

    assign axiov = out_valid_q;
    assign axiod = out_data_q;
    assign axiol = out_last_q;
    assign armed = (state_q == S_ARMED);
    assign busy  = (state_q == S_CAPTURE);
    assign done  = done_q;

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (axiov && !axior) |=> (axiov && $stable(axiod) && $stable(axiol)));

    a_queue_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (occ != 2'd3) && (!skid_valid_q || out_valid_q));

endmodule

// File: tb/tb_capture_window_buffer.sv
// Randomized and directed bench for capture_window_buffer; a queue-based window
// model predicts every output sample, which a decoupled monitor checks on handshake.
module tb_capture_window_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int POST  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          axiiv = 1'b0;
    logic [DW-1:0] axiid = '0;
    logic          trigger = 1'b0;
    logic          axior = 1'b0;
    logic          axiov;
    logic [DW-1:0] axiod;
    logic          axiol;
    logic          armed;
    logic          busy;
    logic          done;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int pop_cnt   = 0;

    // Reference model: the window is the last PRE written samples plus the next
    // POST accepted samples, tagged with a last flag on the final one.
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] hist_q[$];
    bit            capturing = 1'b0;
    bit            prev_trig = 1'b0;
    bit            cap_end_flag = 1'b0;
    int            fill_cnt = 0;
    int            post_rem = 0;
    logic [DW-1:0] seq = '0;

    logic          hold_v = 1'b0;
    logic          hold_l = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          done_exp = 1'b0;
    logic [DW:0]   mon_e;

    capture_window_buffer #(
        .SAMPLE_DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .PRE_SAMPLES(PRE),
        .POST_SAMPLES(POST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .axiiv(axiiv),
        .axiid(axiid),
        .trigger(trigger),
        .axiov(axiov),
        .axiod(axiod),
        .axiol(axiol),
        .axior(axior),
        .armed(armed),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs and advances the model for the edge that samples them.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic trig, input logic rdy);
        bit trig_edge;
        @(posedge clk);
        #1;
        if (cap_end_flag) begin
            capturing    = 1'b0;
            fill_cnt     = 0;
            post_rem     = 0;
            cap_end_flag = 1'b0;
        end
        checkOutput("armed", 32'(armed), 32'(!capturing && fill_cnt >= PRE));
        checkOutput("busy", 32'(busy), 32'(capturing));

        axiiv   = v;
        axiid   = d;
        trigger = trig;
        axior   = rdy;

        trig_edge = trig && !prev_trig;
        prev_trig = trig;
        if (trig_edge && !capturing && fill_cnt >= PRE) begin
            for (int i = 0; i < PRE; i++) begin
                exp_q.push_back({1'b0, hist_q[i]});
            end
            capturing = 1'b1;
            post_rem  = POST;
        end else if (!capturing && v) begin
            fill_cnt++;
        end
        if (v && (!capturing || post_rem > 0)) begin
            if (capturing) begin
                post_rem--;
                exp_q.push_back({(post_rem == 0), d});
            end
            hist_q.push_back(d);
            if (hist_q.size() > PRE) begin
                void'(hist_q.pop_front());
            end
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        axiiv   = 1'b0;
        axiid   = '0;
        trigger = 1'b0;
        axior   = 1'b0;
        #1;
        checkOutput("rst_axiov", 32'(axiov), 32'd0);
        checkOutput("rst_axiod", 32'(axiod), 32'd0);
        checkOutput("rst_axiol", 32'(axiol), 32'd0);
        checkOutput("rst_armed", 32'(armed), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        exp_q.delete();
        hist_q.delete();
        capturing    = 1'b0;
        fill_cnt     = 0;
        post_rem     = 0;
        prev_trig    = 1'b0;
        cap_end_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic feed(input int n, input logic trig, input logic rdy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, seq, trig, rdy);
            seq++;
        end
    endtask

    task automatic drainCapture(input logic trig);
        int n = 0;
        while ((capturing || exp_q.size() != 0) && n < 200) begin
            applyStimulus(post_rem > 0, seq, trig, 1'b1);
            if (post_rem > 0 || capturing) seq++;
            n++;
        end
        total_cnt++;
        if (capturing || exp_q.size() != 0) begin
            bad_cnt++;
            $display("[TB] FAIL drain_timeout: got %0d outputs pending, expected 0", exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v   = 1'b0;
            done_exp = 1'b0;
        end else begin
            checkOutput("done", 32'(done), 32'(done_exp));
            done_exp = 1'b0;
            if (hold_v) begin
                checkOutput("stall_valid", 32'(axiov), 32'd1);
                checkOutput("stall_data", 32'(axiod), 32'(hold_d));
                checkOutput("stall_last", 32'(axiol), 32'(hold_l));
            end
            if (axiov && axior) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    bad_cnt++;
                    $display("[TB] FAIL unexpected_output: got %0h expected no output", axiod);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("out_data", 32'(axiod), 32'(mon_e[DW-1:0]));
                    checkOutput("out_last", 32'(axiol), 32'(mon_e[DW]));
                    if (mon_e[DW]) begin
                        done_exp     = 1'b1;
                        cap_end_flag = 1'b1;
                    end
                end
                pop_cnt++;
                hold_v = 1'b0;
            end else begin
                hold_v = axiov;
                hold_d = axiod;
                hold_l = axiol;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        logic t;

        doReset();

        // History 16..19 then post 20..27.
        seq = '0;
        feed(20, 1'b0, 1'b1);
        applyStimulus(1'b1, seq, 1'b1, 1'b1);
        seq++;
        drainCapture(1'b0);

        // Edge before the window is full is ignored.
        feed(3, 1'b0, 1'b1);
        applyStimulus(1'b0, seq, 1'b1, 1'b1);
        applyStimulus(1'b0, seq, 1'b0, 1'b1);
        feed(1, 1'b0, 1'b1);
        applyStimulus(1'b1, seq, 1'b1, 1'b1);
        seq++;
        drainCapture(1'b0);

        // Consumer toggles ready and then stalls for 10 cycles.
        feed(6, 1'b0, 1'b1);
        applyStimulus(1'b1, seq, 1'b1, 1'b1);
        seq++;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(post_rem > 0, seq, 1'b1,
                          (i >= 10 && i < 20) ? 1'b0 : logic'(i % 2 == 0));
            seq++;
        end
        drainCapture(1'b1);

        // Post samples cross the RAM wrap; also check trigger-to-output latency.
        doReset();
        seq = '0;
        feed(14, 1'b0, 1'b1);
        applyStimulus(1'b1, seq, 1'b1, 1'b1);
        seq++;
        feed(3, 1'b1, 1'b1);
        checkOutput("trig_latency", 32'(axiov), 32'd1);
        drainCapture(1'b1);

        // Trigger held high across and after the capture does not re-fire.
        feed(10, 1'b1, 1'b1);
        applyStimulus(1'b1, seq, 1'b0, 1'b1);
        seq++;
        applyStimulus(1'b1, seq, 1'b1, 1'b1);
        seq++;
        drainCapture(1'b0);

        // Reset in the middle of a capture.
        feed(5, 1'b0, 1'b1);
        applyStimulus(1'b1, seq, 1'b1, 1'b1);
        seq++;
        base = pop_cnt;
        for (int i = 0; i < 50 && pop_cnt < base + 5; i++) begin
            applyStimulus(1'b1, seq, 1'b1, 1'b1);
            seq++;
        end
        checkOutput("mid_capture_outputs", 32'(pop_cnt >= base + 5), 32'd1);
        doReset();
        feed(3, 1'b0, 1'b1);
        feed(2, 1'b0, 1'b1);
        applyStimulus(1'b1, seq, 1'b1, 1'b1);
        seq++;
        drainCapture(1'b0);

        // Randomized traffic with random trigger toggling and backpressure.
        t = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) t = ~t;
            applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), t,
                          $urandom_range(0, 2) != 0);
        end
        drainCapture(t);
        repeat (3) applyStimulus(1'b0, '0, t, 1'b1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
